// File: rtl/cpu_axi_master_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI single-beat master bridge.
package cpu_axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } mst_state_t;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    // Request fields captured when the CPU access is accepted.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } cpu_req_t;

endpackage

// File: rtl/cpu_axi_master.sv
// CPU memory port to AXI4 master bridge: one outstanding single-beat word access,
// CPU stalled for the whole transaction, all bus control outputs registered.
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [3:0]  MASTER_ID = 4'd0,
    parameter logic [31:0] ERR_RDATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_strb,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    // AR
    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,
    // R
    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M,
    // AW
    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    // W
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    // B
    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);

    mst_state_t  state_q, state_d;
    cpu_req_t    req_q, req_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic aw_hs, w_hs, rd_err, wr_err;

    assign aw_hs  = aw_valid_q & AWREADY_M;
    assign w_hs   = w_valid_q & WREADY_M;
    assign rd_err = (RRESP_M != OKAY) || (RID_M != MASTER_ID) || !RLAST_M;
    assign wr_err = (BRESP_M != OKAY) || (BID_M != MASTER_ID);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        cpu_stall  = 1'b1;

        case (state_q)
            IDLE: begin
                cpu_stall = cpu_req;
                if (cpu_req) begin
                    req_d.addr  = cpu_addr;
                    req_d.wdata = cpu_wdata;
                    req_d.strb  = cpu_strb;
                    if (cpu_we) begin
                        state_d    = WADDR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (ARREADY_M) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                if (RVALID_M) begin
                    r_ready_d = 1'b0;
                    err_d     = rd_err;
                    rdata_d   = rd_err ? ERR_RDATA : RDATA_M;
                    state_d   = IDLE;
                end
            end
            WADDR: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                // Both channels may complete in the same cycle, so look at this cycle's handshakes too.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (BVALID_M) begin
                    b_ready_d = 1'b0;
                    err_d     = wr_err;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;

    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = req_q.addr & 32'hFFFF_FFFC;
    assign ARLEN_M   = LEN_SINGLE;
    assign ARSIZE_M  = SIZE_WORD;
    assign ARBURST_M = BURST_INCR;
    assign ARVALID_M = ar_valid_q;
    assign RREADY_M  = r_ready_q;

    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = req_q.addr & 32'hFFFF_FFFC;
    assign AWLEN_M   = LEN_SINGLE;
    assign AWSIZE_M  = SIZE_WORD;
    assign AWBURST_M = BURST_INCR;
    assign AWVALID_M = aw_valid_q;

    assign WDATA_M   = req_q.wdata;
    assign WSTRB_M   = req_q.strb;
    assign WLAST_M   = w_valid_q;
    assign WVALID_M  = w_valid_q;
    assign BREADY_M  = b_ready_q;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Bench for cpu_axi_master: directed vector table, multi-cycle reset sequence, and
// randomized back-to-back traffic checked against a latency/response reference model.
module tb_cpu_axi_master;
    import cpu_axi_master_pkg::*;

    localparam logic [3:0]  MID  = 4'h5;
    localparam logic [31:0] ERRD = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_strb = '0;
    logic        cpu_stall, cpu_err;
    logic [31:0] cpu_rdata;
    logic [3:0]  ARID_M, ARLEN_M, AWID_M, AWLEN_M;
    logic [31:0] ARADDR_M, AWADDR_M, WDATA_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, AWBURST_M;
    logic        ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, WLAST_M, BREADY_M;
    logic [3:0]  WSTRB_M;
    logic        ARREADY_M = 1'b0, RVALID_M = 1'b0, RLAST_M = 1'b0;
    logic        AWREADY_M = 1'b0, WREADY_M = 1'b0, BVALID_M = 1'b0;
    logic [3:0]  RID_M = '0, BID_M = '0;
    logic [31:0] RDATA_M = '0;
    logic [1:0]  RRESP_M = '0, BRESP_M = '0;

    always #5 clk = ~clk;

    cpu_axi_master #(.MASTER_ID(MID), .ERR_RDATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_strb(cpu_strb), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    // d0/d1/d2: AR or AW ready delay, R delay or W ready delay, B delay (cycles)
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          d0, d1, d2;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_chk = 0, n_pass = 0;
    logic        pend = 1'b0;
    logic        exp_err_q = 1'b0;
    logic [31:0] exp_rdata_q = '0;
    vec_t        tbl[10];
    vec_t        rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    endtask

    // Reference: outcome and stall length from the response fields and handshake delays.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        if (v.we) begin
            r.exp_err = (v.resp != OKAY) || (v.id != MID);
            r.exp_lat = 3 + ((v.d0 > v.d1) ? v.d0 : v.d1) + v.d2;
        end else begin
            r.exp_err   = (v.resp != OKAY) || (v.id != MID) || !v.last;
            r.exp_lat   = 3 + v.d0 + v.d1;
            r.exp_rdata = r.exp_err ? ERRD : v.rdata;
        end
        return r;
    endfunction

    // Entered just after a posedge; returns just after the posedge ending the final handshake
    // cycle, with cpu_req still high so the caller may chain the next request with no bubble.
    task automatic run_txn(input vec_t t);
        int cyc = 0, nst = 0, nav = 0, naw = 0, nw = 0, nearly = 0;
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
        bit ar_done = 0, aw_done = 0, w_done = 0, done = 0, ar_hs, aw_hs, w_hs;
        logic [31:0] baddr;
        baddr     = t.addr & 32'hFFFF_FFFC;
        cpu_req   = 1'b1;
        cpu_we    = t.we;
        cpu_addr  = t.addr;
        cpu_wdata = t.wdata;
        cpu_strb  = t.strb;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (cyc == 0 && pend) begin
                chk("prev_rdata", cpu_rdata, exp_rdata_q);
                chk("prev_err", {31'b0, cpu_err}, {31'b0, exp_err_q});
                pend = 1'b0;
            end
            if (cyc == 1) chk("err_pulse_len", {31'b0, cpu_err}, 32'd0);
            if (cpu_stall) nst++;
            ARREADY_M = 1'b0; RVALID_M = 1'b0; AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0;
            ar_hs = 0; aw_hs = 0; w_hs = 0;
            if (!t.we) begin
                if (ARVALID_M) begin
                    nav++;
                    chk("araddr", ARADDR_M, baddr);
                    chk("arid", {28'b0, ARID_M}, {28'b0, MID});
                    ARREADY_M = (ar_cnt >= t.d0);
                    ar_cnt++;
                    ar_hs = ARREADY_M;
                end else begin
                    ARREADY_M = (t.d0 == 0);
                end
                if (ar_done) begin
                    RVALID_M = (r_cnt >= t.d1);
                    r_cnt++;
                    RDATA_M = t.rdata; RRESP_M = t.resp; RID_M = t.id; RLAST_M = t.last;
                    if (RVALID_M && RREADY_M) done = 1;
                end
            end else begin
                if (AWVALID_M) begin
                    naw++;
                    chk("awaddr", AWADDR_M, baddr);
                    AWREADY_M = (aw_cnt >= t.d0);
                    aw_cnt++;
                    aw_hs = AWREADY_M;
                end
                if (WVALID_M) begin
                    nw++;
                    chk("wdata", WDATA_M, t.wdata);
                    chk("wstrb_wlast", {27'b0, WLAST_M, WSTRB_M}, {27'b0, 1'b1, t.strb});
                    WREADY_M = (w_cnt >= t.d1);
                    w_cnt++;
                    w_hs = WREADY_M;
                end
                if (BREADY_M && (AWVALID_M || WVALID_M)) nearly++;
                if (aw_done && w_done) begin
                    BVALID_M = (b_cnt >= t.d2);
                    b_cnt++;
                    BRESP_M = t.resp; BID_M = t.id;
                    if (BVALID_M && BREADY_M) done = 1;
                end
            end
            ar_done |= ar_hs; aw_done |= aw_hs; w_done |= w_hs;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("completed", {31'b0, done}, 32'd1);
        chk("latency", cyc, t.exp_lat);
        chk("stall_cycles", nst, t.exp_lat);
        if (!t.we) begin
            chk("arvalid_cycles", nav, t.d0 + 1);
        end else begin
            chk("awvalid_cycles", naw, t.d0 + 1);
            chk("wvalid_cycles", nw, t.d1 + 1);
            chk("bready_early", nearly, 0);
        end
        pend      = 1'b1;
        exp_err_q = t.exp_err;
        if (!t.we) exp_rdata_q = t.exp_rdata;
    endtask

    // Drops the request and checks the completion cycle, then the cycle after.
    task automatic idle_check();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rdata", cpu_rdata, exp_rdata_q);
        chk("err", {31'b0, cpu_err}, {31'b0, exp_err_q});
        pend = 1'b0;
        @(negedge clk);
        chk("err_pulse_len", {31'b0, cpu_err}, 32'd0);
        chk("rdata_hold", cpu_rdata, exp_rdata_q);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, OKAY, MID, 1'b1, 1'b0, 3, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 0, 3, 0, 32'h0, OKAY, MID, 1'b1, 1'b0, 6, 32'h0};
        tbl[2] = '{1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 4'b1111, 1, 1, 0, 32'h0, OKAY, MID, 1'b1, 1'b0, 4, 32'h0};
        tbl[3] = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 2, 0, 32'h1111_2222, SLVERR, MID, 1'b1, 1'b1, 6, ERRD};
        tbl[4] = '{1'b1, 32'h0000_0020, 32'h0000_CAFE, 4'b0100, 0, 0, 1, 32'h0, OKAY, 4'h4, 1'b1, 1'b1, 4, 32'h0};
        tbl[5] = '{1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 0, 32'h3333_4444, OKAY, MID, 1'b0, 1'b1, 3, ERRD};
        tbl[6] = '{1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 1, 0, 32'h0000_5555, OKAY, 4'h6, 1'b1, 1'b1, 4, ERRD};
        tbl[7] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, 2, 0, 2, 32'h0, OKAY, MID, 1'b1, 1'b0, 7, 32'h0};
        tbl[8] = '{1'b0, 32'h0000_0107, 32'h0, 4'h0, 2, 1, 0, 32'h7777_8888, OKAY, MID, 1'b1, 1'b0, 6, 32'h7777_8888};
        tbl[9] = '{1'b1, 32'h0000_0044, 32'h0000_0009, 4'b1000, 0, 5, 1, 32'h0, SLVERR, MID, 1'b1, 1'b1, 9, 32'h0};

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid_ready", {26'b0, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, WLAST_M, BREADY_M}, 32'd0);
        chk("rst_cpu", {cpu_rdata[30:0], cpu_err}, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("const_ar", {23'b0, ARLEN_M, ARSIZE_M, ARBURST_M}, {23'b0, 4'd0, 3'b010, 2'b01});
        chk("const_aw", {23'b0, AWLEN_M, AWSIZE_M, AWBURST_M}, {23'b0, 4'd0, 3'b010, 2'b01});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed table, each access isolated by an idle cycle.
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i]);
            idle_check();
        end

        // Reset while ARVALID is held by a slave that never becomes ready.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500;
        @(negedge clk);
        ARREADY_M = 1'b0;
        @(negedge clk);
        chk("rst_seq_arvalid", {31'b0, ARVALID_M}, 32'd1);
        @(negedge clk);
        chk("rst_seq_arvalid_hold", {ARVALID_M, ARADDR_M[30:0]}, {1'b1, 31'h0000_0500});
        #2 rst = 1'b0; cpu_req = 1'b0;
        #1;
        chk("rst_async_valids", {26'b0, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, WLAST_M, BREADY_M}, 32'd0);
        chk("rst_async_rdata", cpu_rdata, 32'd0);
        chk("rst_async_stall", {31'b0, cpu_stall}, 32'd0);
        exp_rdata_q = '0; exp_err_q = 1'b0; pend = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        run_txn(model('{1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 0, 0, 32'h0BAD_F00D, OKAY, MID, 1'b1, 1'b0, 0, 32'h0}));
        idle_check();

        // Randomized back-to-back traffic with 0-5 cycle handshake delays.
        for (int k = 0; k < 40; k++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.strb  = 4'($urandom_range(0, 15));
            rv.d0    = int'($urandom_range(0, 5));
            rv.d1    = int'($urandom_range(0, 5));
            rv.d2    = int'($urandom_range(0, 5));
            rv.rdata = $urandom;
            rv.resp  = ($urandom_range(0, 7) == 0) ? SLVERR : OKAY;
            rv.id    = ($urandom_range(0, 9) == 0) ? (MID ^ 4'h1) : MID;
            rv.last  = ($urandom_range(0, 9) != 0);
            rv.exp_err = 1'b0; rv.exp_lat = 0; rv.exp_rdata = '0;
            run_txn(model(rv));
        end
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
